// File: rtl/predict_hls_deadlock_monitor_param.sv
// ============================================================================
// predict_hls_deadlock_monitor_param
// ----------------------------------------------------------------------------
// Purpose:
//   Parametrised deadlock monitor for one HLS dataflow region of the
//   `predict` hierarchy. It watches N_AXIS AXI-Stream "blocked" flags (each
//   with an enable mask) and N_INST sub-instance monitor outputs (qualified
//   by their idle flags). Blocking is reported only after it has persisted
//   for THRESHOLD consecutive cycles. On detection it captures a snapshot
//   of the contributing sources and counts, with saturation, how many cycles
//   the deadlock condition has remained true. With STICKY=1 the report
//   holds until `clear`.
//
// Parameters:
//   N_AXIS    - number of AXI-Stream block inputs (>=1)
//   N_INST    - number of sub-instance block/idle inputs (>=1)
//   THRESHOLD - consecutive qualified-block cycles needed to declare deadlock
//   STICKY    - 1: block holds until clear, 0: block follows the condition
//   DUR_W     - width of block_cycles
//
// Ports:
//   clock           in  - single clock, rising edge
//   reset           in  - synchronous, active-low
//   axis_block_sigs in  [N_AXIS] - per-channel stream blocked
//   axis_enable     in  [N_AXIS] - per-channel mask (0 ignores the channel)
//   inst_idle_sigs  in  [N_INST] - sub-instance idle
//   inst_block_sigs in  [N_INST] - sub-instance monitor block outputs
//   clear           in  - synchronous clear of detection state
//   block           out - deadlock detected (registered)
//   block_vec       out [N_AXIS+N_INST] - {inst, axis} snapshot at detection
//   block_cycles    out [DUR_W] - saturating cycles in deadlock with cand=1
// ============================================================================
module predict_hls_deadlock_monitor_param #(
    parameter int N_AXIS    = 2,
    parameter int N_INST    = 1,
    parameter int THRESHOLD = 1,
    parameter int STICKY    = 0,
    parameter int DUR_W     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_AXIS-1:0]          axis_block_sigs,
    input  logic [N_AXIS-1:0]          axis_enable,
    input  logic [N_INST-1:0]          inst_idle_sigs,
    input  logic [N_INST-1:0]          inst_block_sigs,
    input  logic                       clear,
    output logic                       block,
    output logic [N_AXIS+N_INST-1:0]   block_vec,
    output logic [DUR_W-1:0]           block_cycles
);

    localparam int VEC_W = N_AXIS + N_INST;
    localparam int CNT_W = $clog2(THRESHOLD + 1);

    // Count value at which one more qualified cycle completes the threshold.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUSPECT,
        ST_DEADLOCK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               block_q, block_d;
    logic [VEC_W-1:0]   block_vec_q, block_vec_d;
    logic [DUR_W-1:0]   block_cycles_q, block_cycles_d;

    logic [N_AXIS-1:0]  axis_masked;
    logic [N_INST-1:0]  inst_masked;
    logic               cand;
    logic               enter_deadlock;

    // Qualified blocking candidate. An idle sub-instance cannot be part of a
    // deadlock, so its block flag is suppressed by its idle flag.
    always_comb begin
        axis_masked = axis_block_sigs & axis_enable;
        inst_masked = inst_block_sigs & ~inst_idle_sigs;
        cand        = (|axis_masked) | (|inst_masked);
    end

    // Next-state logic. The persistence counter only runs in SUSPECT; entry
    // into DEADLOCK captures the snapshot and restarts the duration count.
    // A clear overrides everything decided above it in the same cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        block_vec_d    = block_vec_q;
        block_cycles_d = block_cycles_q;
        enter_deadlock = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cand) begin
                    if (THRESHOLD == 1) begin
                        state_d        = ST_DEADLOCK;
                        enter_deadlock = 1'b1;
                    end else begin
                        state_d = ST_SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            ST_SUSPECT: begin
                if (!cand) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = ST_DEADLOCK;
                    cnt_d          = '0;
                    enter_deadlock = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DEADLOCK: begin
                cnt_d = '0;
                if (cand) begin
                    if (block_cycles_q != DUR_MAX) begin
                        block_cycles_d = block_cycles_q + DUR_W'(1);
                    end
                end else if (STICKY == 0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enter_deadlock) begin
            block_vec_d    = {inst_masked, axis_masked};
            block_cycles_d = DUR_W'(1);
        end

        if (clear) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            block_vec_d    = '0;
            block_cycles_d = '0;
        end

        block_d = (state_d == ST_DEADLOCK);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            block_q        <= 1'b0;
            block_vec_q    <= '0;
            block_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            block_q        <= block_d;
            block_vec_q    <= block_vec_d;
            block_cycles_q <= block_cycles_d;
        end
    end

    assign block        = block_q;
    assign block_vec    = block_vec_q;
    assign block_cycles = block_cycles_q;

endmodule

// File: tb/tb_predict_hls_deadlock_monitor_param.sv
// ============================================================================
// tb_predict_hls_deadlock_monitor_param
// ----------------------------------------------------------------------------
// Three monitors with different configurations share one set of inputs:
//   dut_a : THRESHOLD=4, STICKY=0, DUR_W=16
//   dut_b : THRESHOLD=1, STICKY=1, DUR_W=16
//   dut_c : THRESHOLD=3, STICKY=0, DUR_W=3
// A reference model tracks, per configuration, the length of the current
// run of consecutive blocking cycles and whether deadlock has been declared.
// ============================================================================
module tb_predict_hls_deadlock_monitor_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  axis_block_sigs;
    logic [3:0]  axis_enable;
    logic [1:0]  inst_idle_sigs;
    logic [1:0]  inst_block_sigs;
    logic        clear;

    logic        block_a, block_b, block_c;
    logic [5:0]  vec_a, vec_b, vec_c;
    logic [15:0] bc_a, bc_b;
    logic [2:0]  bc_c;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    predict_hls_deadlock_monitor_param #(
        .N_AXIS(4), .N_INST(2), .THRESHOLD(4), .STICKY(0), .DUR_W(16)
    ) dut_a (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis_block_sigs), .axis_enable(axis_enable),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .clear(clear), .block(block_a), .block_vec(vec_a), .block_cycles(bc_a)
    );

    predict_hls_deadlock_monitor_param #(
        .N_AXIS(4), .N_INST(2), .THRESHOLD(1), .STICKY(1), .DUR_W(16)
    ) dut_b (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis_block_sigs), .axis_enable(axis_enable),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .clear(clear), .block(block_b), .block_vec(vec_b), .block_cycles(bc_b)
    );

    predict_hls_deadlock_monitor_param #(
        .N_AXIS(4), .N_INST(2), .THRESHOLD(3), .STICKY(0), .DUR_W(3)
    ) dut_c (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis_block_sigs), .axis_enable(axis_enable),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .clear(clear), .block(block_c), .block_vec(vec_c), .block_cycles(bc_c)
    );

    // Reference model: per-configuration run length, detection flag,
    // captured snapshot and duration.
    int          m_thr [3] = '{4, 1, 3};
    bit          m_stk [3] = '{1'b0, 1'b1, 1'b0};
    int          m_sat [3] = '{65535, 65535, 7};
    int          m_run [3];
    bit          m_det [3];
    logic [5:0]  m_vec [3];
    int          m_cyc [3];

    logic [3:0]  mdl_am;
    logic [1:0]  mdl_im;
    bit          mdl_cand;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_det[i] = 1'b0; m_vec[i] = '0; m_cyc[i] = 0;
        end
    end

    // The model advances on every rising edge from the inputs the DUTs see.
    always @(posedge clock) begin
        mdl_am   = axis_block_sigs & axis_enable;
        mdl_im   = inst_block_sigs & ~inst_idle_sigs;
        mdl_cand = (mdl_am != 4'd0) || (mdl_im != 2'd0);
        for (int i = 0; i < 3; i++) begin
            if (!reset || clear) begin
                m_run[i] = 0; m_det[i] = 1'b0; m_vec[i] = '0; m_cyc[i] = 0;
            end else if (m_det[i]) begin
                if (mdl_cand) begin
                    if (m_cyc[i] < m_sat[i]) m_cyc[i] = m_cyc[i] + 1;
                end else if (!m_stk[i]) begin
                    m_det[i] = 1'b0;
                    m_run[i] = 0;
                end
            end else if (mdl_cand) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= m_thr[i]) begin
                    m_det[i] = 1'b1;
                    m_cyc[i] = 1;
                    m_vec[i] = {mdl_im, mdl_am};
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return at the next falling edge, when
    // the outputs reflect the rising edge that consumed those inputs.
    task automatic applyStimulus(input logic rst_n, input logic clr,
                                 input logic [3:0] ab, input logic [3:0] en,
                                 input logic [1:0] ib, input logic [1:0] idl);
        reset           = rst_n;
        clear           = clr;
        axis_block_sigs = ab;
        axis_enable     = en;
        inst_block_sigs = ib;
        inst_idle_sigs  = idl;
        @(negedge clock);
    endtask

    // Every-cycle comparison of all three DUTs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("a.block", 32'(block_a), 32'(m_det[0]));
            checkOutput("a.vec",   32'(vec_a),   32'(m_vec[0]));
            checkOutput("a.cyc",   32'(bc_a),    32'(m_cyc[0]));
            checkOutput("b.block", 32'(block_b), 32'(m_det[1]));
            checkOutput("b.vec",   32'(vec_b),   32'(m_vec[1]));
            checkOutput("b.cyc",   32'(bc_b),    32'(m_cyc[1]));
            checkOutput("c.block", 32'(block_c), 32'(m_det[2]));
            checkOutput("c.vec",   32'(vec_c),   32'(m_vec[2]));
            checkOutput("c.cyc",   32'(bc_c),    32'(m_cyc[2]));
        end
    end

    logic [3:0] gap_pat [8] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};

    initial begin
        reset = 1'b0; clear = 1'b0;
        axis_block_sigs = '0; axis_enable = 4'hF;
        inst_block_sigs = '0; inst_idle_sigs = '0;

        // Reset and reset-state checks.
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
        chk_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
        checkOutput("reset.block_a", 32'(block_a), 32'd0);
        checkOutput("reset.vec_a",   32'(vec_a),   32'd0);
        checkOutput("reset.cyc_a",   32'(bc_a),    32'd0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);

        // Hold one stream blocked for six cycles on the threshold-4 monitor.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0100, 4'hF, 2'b00, 2'b00);
            if (k == 3) checkOutput("thr.before", 32'(block_a), 32'd0);
            if (k == 4) begin
                checkOutput("thr.rise", 32'(block_a), 32'd1);
                checkOutput("thr.vec",  32'(vec_a),   32'b000100);
                checkOutput("thr.cyc1", 32'(bc_a),    32'd1);
            end
            if (k == 6) checkOutput("thr.cyc3", 32'(bc_a), 32'd3);
        end
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
        checkOutput("thr.fall",     32'(block_a), 32'd0);
        checkOutput("thr.cyc_hold", 32'(bc_a),    32'd3);

        // A one-cycle gap restarts the persistence count.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, gap_pat[k], 4'hF, 2'b00, 2'b00);
            checkOutput("gap.block_a", 32'(block_a), 32'd0);
        end

        // Masked channel and idle sub-instance never contribute.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1110, 2'b00, 2'b00);
            checkOutput("mask.block_a", 32'(block_a), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1110, 2'b10, 2'b10);
            checkOutput("idle.block_a", 32'(block_a), 32'd0);
        end
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1110, 2'b10, 2'b00);
            if (k == 3) checkOutput("inst.before", 32'(block_a), 32'd0);
        end
        checkOutput("inst.rise", 32'(block_a), 32'd1);
        checkOutput("inst.vec",  32'(vec_a),   32'b100000);

        // Sticky single-cycle detection and clear priority.
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF, 2'b00, 2'b00);
        checkOutput("sticky.rise", 32'(block_b), 32'd1);
        checkOutput("sticky.cyc",  32'(bc_b),    32'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 2'b00, 2'b00);
            checkOutput("sticky.hold",     32'(block_b), 32'd1);
            checkOutput("sticky.cyc_hold", 32'(bc_b),    32'd1);
        end
        applyStimulus(1'b1, 1'b1, 4'b0001, 4'hF, 2'b00, 2'b00);
        checkOutput("clear.block_b", 32'(block_b), 32'd0);
        checkOutput("clear.vec_b",   32'(vec_b),   32'd0);
        checkOutput("clear.cyc_b",   32'(bc_b),    32'd0);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF, 2'b00, 2'b00);
        checkOutput("redetect.block_b", 32'(block_b), 32'd1);
        checkOutput("redetect.vec_b",   32'(vec_b),   32'b000001);

        // Duration counter saturation on the narrow monitor.
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF, 2'b00, 2'b00);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0010, 4'hF, 2'b00, 2'b00);
        end
        checkOutput("sat.cyc_c",   32'(bc_c),    32'd7);
        checkOutput("sat.block_c", 32'(block_c), 32'd1);
        checkOutput("wide.cyc_a",  32'(bc_a),    32'd9);

        // Reset during DEADLOCK, then re-detection with the condition held.
        applyStimulus(1'b0, 1'b0, 4'b0010, 4'hF, 2'b00, 2'b00);
        checkOutput("rst.block_a", 32'(block_a), 32'd0);
        checkOutput("rst.cyc_a",   32'(bc_a),    32'd0);
        checkOutput("rst.block_b", 32'(block_b), 32'd0);
        checkOutput("rst.vec_c",   32'(vec_c),   32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0010, 4'hF, 2'b00, 2'b00);
            if (k == 1) checkOutput("rel.block_b", 32'(block_b), 32'd1);
            if (k == 3) checkOutput("rel.block_a_early", 32'(block_a), 32'd0);
            if (k == 4) checkOutput("rel.block_a", 32'(block_a), 32'd1);
        end

        // Deterministic mixed pattern: mask changes, inst/idle interplay,
        // occasional clear; checked by the model every cycle.
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'b1, (k % 17) == 16,
                          4'((k / 3) ^ (k / 7)), 4'(15 - (k / 10)),
                          2'(k / 5), 2'(k / 9));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/predict_hls_deadlock_monitor_param.md
# predict_hls_deadlock_monitor_param

Parametrised deadlock monitor for the `predict` HLS hierarchy. It generalises the per-instance monitor to N AXI-Stream channels and M sub-instances, with a per-channel enable mask and a persistence threshold. Blocking is only reported once it has held for a configurable number of consecutive cycles. It adds optional sticky reporting, a snapshot of which sources were blocking at detection, and a saturating blocked-duration counter. One instance sits beside each HLS dataflow region, and its `block` output feeds the parent monitor's `inst_block_sigs`.

## Interface
Parameters:
- `N_AXIS`, 2 — number of AXI-Stream block inputs (≥1)
- `N_INST`, 1 — number of sub-instance block/idle inputs (≥1)
- `THRESHOLD`, 1 — consecutive qualified-block cycles required to declare deadlock (≥1; 1 reproduces the single-cycle behaviour)
- `STICKY`, 0 — 1: `block` holds until `clear`; 0: `block` follows the condition
- `DUR_W`, 16 — width of `block_cycles`

Ports:
- `clock` in 1 — the single clock; all state updates on its rising edge
- `reset` in 1 — synchronous, active-low; samples low → all state to reset values
- `axis_block_sigs` in N_AXIS — per-channel stream blocked
- `axis_enable` in N_AXIS — per-channel mask; 0 ignores that channel
- `inst_idle_sigs` in N_INST — sub-instance idle
- `inst_block_sigs` in N_INST — sub-instance monitor block outputs
- `clear` in 1 — synchronous clear of detection state (sticky release)
- `block` out 1 — deadlock detected (registered)
- `block_vec` out N_AXIS+N_INST — snapshot at detection: {masked inst_block, masked axis_block}, inst in MSBs
- `block_cycles` out DUR_W — cycles spent in DEADLOCK with condition true, saturating

## Operation
- Combinational candidate: `axis_hit = |(axis_block_sigs & axis_enable)`; `inst_hit = |(inst_block_sigs & ~inst_idle_sigs)` (an idle sub-instance never contributes); `cand = axis_hit | inst_hit`.
- Persistence counter `cnt`, width clog2(THRESHOLD+1), never exceeds THRESHOLD-1 outside DEADLOCK.
- FSM states: IDLE, SUSPECT, DEADLOCK.
  - IDLE: `cnt=0`. On cand → DEADLOCK if THRESHOLD==1, else SUSPECT with `cnt=1`.
  - SUSPECT: on !cand → IDLE, `cnt=0`. On cand with `cnt==THRESHOLD-1` → DEADLOCK. Otherwise `cnt++`.
  - DEADLOCK: `block=1`. On !cand: STICKY=0 → IDLE; STICKY=1 → stay.
- On every entry to DEADLOCK: `block_vec` ← {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs & axis_enable}, sampled in the entering cycle, and `block_cycles` ← 1. Both hold otherwise.
- While in DEADLOCK with cand=1: `block_cycles++`, saturating at 2^DUR_W-1. No increment when cand=0 (sticky hold).
- `clear`=1 (reset inactive): next state IDLE, `cnt=0`, `block_vec=0`, `block_cycles=0`. Takes priority over cand in the same cycle. Re-detection starts fresh the cycle after `clear` deasserts.
- Mask changes take effect immediately in `cand`. They do not alter a captured `block_vec`.

## Timing
- Reset values: `block=0`, `block_vec=0`, `block_cycles=0`, state IDLE, `cnt=0`.
- Latency: with cand continuously high from cycle t, `block` rises at the edge ending cycle t+THRESHOLD-1, i.e. it is visible in cycle t+THRESHOLD. THRESHOLD=1 gives one-cycle latency.
- A cand drop of even one cycle in SUSPECT restarts the count.
- STICKY=0: `block` falls the cycle after cand falls.
- Reset mid-SUSPECT or mid-DEADLOCK: everything returns to reset values next cycle, regardless of `clear`/cand.
- `block` is purely registered. No combinational path from inputs to outputs.

## Test plan
- N_AXIS=4, N_INST=2, THRESHOLD=4, STICKY=0, mask 4'b1111. Hold axis_block=4'b0100 for 6 cycles from t=10 → `block`=1 in cycles 14–16; `block_vec`=6'b000100; `block_cycles`=3 at cycle 16; `block`=0 at cycle 17.
- Same config. axis_block=4'b0001 for 3 cycles, 1 cycle low, then 3 cycles high → `block` never asserts.
- mask=4'b1110, axis_block=4'b0001 for 10 cycles → `block` stays 0. Then inst_block=2'b10, inst_idle=2'b10 → still 0. Set inst_idle=2'b00 → `block` asserts 4 cycles later with `block_vec`=6'b100000.
- STICKY=1, THRESHOLD=1. Pulse axis_block[0] for 1 cycle → `block` asserts next cycle and holds, `block_cycles`=1. Assert `clear` coincident with a new cand → IDLE, all outputs 0. Re-detect one cycle after `clear` drops.
- DUR_W=3. Hold cand for 12 cycles → `block_cycles` saturates at 7.
- Drive `reset`=0 for one cycle while in DEADLOCK → all outputs 0 next cycle. With cand still high, `block` re-asserts THRESHOLD cycles after reset release.
